// File: rtl/dmmu_utlb.sv
// dmmu_utlb: data-side MMU front end.
// Fully-associative micro-TLB, refilled from the main TLB.
module dmmu_utlb #(
  parameter  int ENTRIES = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic        req_wr,
  output logic        resp_valid,
  output logic [19:0] resp_tag,
  output logic        resp_uncache,
  output logic        resp_exc,
  output logic [4:0]  resp_exccode,
  output logic        resp_refill,
  output logic        tlb_req,
  output logic [18:0] tlb_vpn2,
  output logic        tlb_odd,
  output logic [7:0]  tlb_asid,
  input  logic        tlb_ack,
  input  logic        tlb_hit,
  input  logic        tlb_g,
  input  logic        tlb_d,
  input  logic        tlb_v,
  input  logic [19:0] tlb_pfn,
  input  logic [2:0]  tlb_c,
  input  logic        flush,
  input  logic [7:0]  cp0_asid,
  input  logic [2:0]  cp0_k0
);

  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;

  typedef enum logic [1:0] {
    IDLE, CHECK, WAIT, FILL
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [19:0] vpn;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } ent_t;

  typedef struct packed {
    logic [19:0] tag;
    logic        uncache;
    logic        exc;
    logic [4:0]  code;
    logic        refill;
  } resp_t;

  state_t           state;
  ent_t             ent [ENTRIES];
  logic [IDX_W-1:0] ptr;
  logic [19:0]      vpn;
  logic             wr;
  logic [7:0]       asid;
  logic             drop_fill;
  logic             f_g;
  logic             f_d;
  logic [19:0]      f_pfn;
  logic [2:0]       f_c;
  resp_t            resp;

  logic        hit;
  logic [19:0] hit_pfn;
  logic [2:0]  hit_c;
  logic        hit_d;
  logic        k0;
  logic        k1;
  logic        mapped;
  logic        unused_off;

  assign unused_off = ^req_vaddr[11:0];

  assign k0     = (vpn[19:17] == 3'b100);
  assign k1     = (vpn[19:17] == 3'b101);
  assign mapped = !k0 && !k1;

  assign req_ready    = (state == IDLE);
  assign tlb_vpn2     = vpn[19:1];
  assign tlb_odd      = vpn[0];
  assign tlb_asid     = asid;
  assign resp_tag     = resp.tag;
  assign resp_uncache = resp.uncache;
  assign resp_exc     = resp.exc;
  assign resp_exccode = resp.code;
  assign resp_refill  = resp.refill;

  // fill rule keeps matches one-hot, so OR-merge is safe
  always_comb begin
    hit     = 1'b0;
    hit_pfn = '0;
    hit_c   = '0;
    hit_d   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent[i].valid && ent[i].v &&
          ent[i].vpn == vpn &&
          (ent[i].g || ent[i].asid == asid)) begin
        hit     = 1'b1;
        hit_pfn = hit_pfn | ent[i].pfn;
        hit_c   = hit_c | ent[i].c;
        hit_d   = hit_d | ent[i].d;
      end
    end
  end

  function automatic resp_t ok_resp(
    input logic [19:0] tag,
    input logic        unc,
    input logic        mod
  );
    ok_resp.tag     = tag;
    ok_resp.uncache = unc;
    ok_resp.exc     = mod;
    ok_resp.code    = mod ? EXC_MOD : 5'd0;
    ok_resp.refill  = 1'b0;
  endfunction

  function automatic resp_t exc_resp(
    input logic st,
    input logic refill
  );
    exc_resp.tag     = '0;
    exc_resp.uncache = 1'b0;
    exc_resp.exc     = 1'b1;
    exc_resp.code    = st ? EXC_TLBS : EXC_TLBL;
    exc_resp.refill  = refill;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      drop_fill  <= 1'b0;
      tlb_req    <= 1'b0;
      resp_valid <= 1'b0;
      resp       <= '0;
      vpn        <= '0;
      wr         <= 1'b0;
      asid       <= '0;
      f_g        <= 1'b0;
      f_d        <= 1'b0;
      f_pfn      <= '0;
      f_c        <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ent[i].valid <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          drop_fill <= 1'b0;
          if (req_valid) begin
            vpn   <= req_vaddr[31:12];
            wr    <= req_wr;
            asid  <= cp0_asid;
            state <= CHECK;
          end
        end
        CHECK: begin
          unique case (1'b1)
            k0: begin
              resp <= ok_resp({3'b0, vpn[16:0]},
                              cp0_k0 != 3'd3, 1'b0);
              resp_valid <= 1'b1;
              state      <= IDLE;
            end
            k1: begin
              resp <= ok_resp({3'b0, vpn[16:0]},
                              1'b1, 1'b0);
              resp_valid <= 1'b1;
              state      <= IDLE;
            end
            (mapped && hit): begin
              resp <= ok_resp(hit_pfn, hit_c != 3'd3,
                              wr && !hit_d);
              resp_valid <= 1'b1;
              state      <= IDLE;
            end
            (mapped && !hit): begin
              tlb_req <= 1'b1;
              state   <= WAIT;
            end
          endcase
        end
        WAIT: begin
          if (flush)
            drop_fill <= 1'b1;
          if (tlb_ack) begin
            tlb_req <= 1'b0;
            if (tlb_hit && tlb_v && (drop_fill || flush)) begin
              // answer from ack data; a flushed fill is never written
              resp <= ok_resp(tlb_pfn, tlb_c != 3'd3,
                              wr && !tlb_d);
              resp_valid <= 1'b1;
              state      <= IDLE;
            end else if (tlb_hit && tlb_v) begin
              f_g   <= tlb_g;
              f_d   <= tlb_d;
              f_pfn <= tlb_pfn;
              f_c   <= tlb_c;
              state <= FILL;
            end else begin
              resp       <= exc_resp(wr, !tlb_hit);
              resp_valid <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        FILL: begin
          ent[ptr] <= '{valid: 1'b1, vpn: vpn,
                        asid: asid, g: f_g,
                        pfn: f_pfn, c: f_c,
                        d: f_d, v: 1'b1};
          ptr   <= ptr + 1'b1;
          state <= CHECK;
        end
        default: state <= IDLE;
      endcase
      if (flush)
        for (int i = 0; i < ENTRIES; i++)
          ent[i].valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmmu_utlb.sv
// tb_dmmu_utlb: scoreboard bench for the data-side uTLB.
// Directed vectors; a negedge monitor pops expected responses.
module tb_dmmu_utlb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_vaddr = '0;
  logic        req_wr = 1'b0;
  logic        resp_valid;
  logic [19:0] resp_tag;
  logic        resp_uncache;
  logic        resp_exc;
  logic [4:0]  resp_exccode;
  logic        resp_refill;
  logic        tlb_req;
  logic [18:0] tlb_vpn2;
  logic        tlb_odd;
  logic [7:0]  tlb_asid;
  logic        tlb_ack = 1'b0;
  logic        tlb_hit = 1'b0;
  logic        tlb_g = 1'b0;
  logic        tlb_d = 1'b0;
  logic        tlb_v = 1'b0;
  logic [19:0] tlb_pfn = '0;
  logic [2:0]  tlb_c = '0;
  logic        flush = 1'b0;
  logic [7:0]  cp0_asid = 8'd5;
  logic [2:0]  cp0_k0 = 3'd3;

  always #5 clk = ~clk;

  dmmu_utlb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_wr(req_wr),
    .resp_valid(resp_valid), .resp_tag(resp_tag),
    .resp_uncache(resp_uncache), .resp_exc(resp_exc),
    .resp_exccode(resp_exccode),
    .resp_refill(resp_refill),
    .tlb_req(tlb_req), .tlb_vpn2(tlb_vpn2),
    .tlb_odd(tlb_odd), .tlb_asid(tlb_asid),
    .tlb_ack(tlb_ack), .tlb_hit(tlb_hit),
    .tlb_g(tlb_g), .tlb_d(tlb_d), .tlb_v(tlb_v),
    .tlb_pfn(tlb_pfn), .tlb_c(tlb_c),
    .flush(flush), .cp0_asid(cp0_asid),
    .cp0_k0(cp0_k0)
  );

  typedef struct packed {
    logic [19:0] tag;
    logic        unc;
    logic        exc;
    logic [4:0]  code;
    logic        refill;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;
  int req_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && tlb_req)
      req_seen <= req_seen + 1;
    if (rst && resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      resp_cyc <= cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp",
            {4'b0, resp_tag, resp_uncache, resp_exc,
             resp_exccode, resp_refill},
            {4'b0, e});
      end
    end
  end

  task automatic issue(input logic [31:0] va,
                       input logic w,
                       output int acc);
    @(negedge clk);
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_vaddr = va;
    req_wr    = w;
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n0, input string nm);
    for (int i = 0; i < 40 && resp_cnt == n0; i++)
      @(posedge clk);
    chk({nm, "_timeout"},
        {31'b0, resp_cnt > n0}, 32'd1);
  endtask

  // hit or unmapped access: answer one edge after accept
  task automatic xlate(input string nm,
                       input logic [31:0] va,
                       input logic w,
                       input exp_t e,
                       input bit chg = 1'b0,
                       input logic [7:0] na = 8'd0);
    int acc;
    int n0;
    int r0;
    n0 = resp_cnt;
    r0 = req_seen;
    exp_q.push_back(e);
    issue(va, w, acc);
    if (chg) cp0_asid = na;
    wait_resp(n0, nm);
    chk({nm, "_lat"}, resp_cyc - acc, 32'd1);
    chk({nm, "_noreq"}, req_seen - r0, 32'd0);
  endtask

  // fl: 0 none, 1 flush in WAIT, 2 flush on ack cycle
  task automatic miss(input string nm,
                      input logic [31:0] va,
                      input logic w,
                      input logic [7:0] asid_exp,
                      input logic h, input logic g,
                      input logic d, input logic v,
                      input logic [19:0] pfn,
                      input logic [2:0] c,
                      input int fl,
                      input exp_t e,
                      input int lat);
    int acc;
    int n0;
    int ackc;
    bit seen;
    n0 = resp_cnt;
    exp_q.push_back(e);
    issue(va, w, acc);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = tlb_req;
    end
    chk({nm, "_req"}, {31'b0, seen}, 32'd1);
    if (!seen) return;
    chk({nm, "_look"},
        {4'b0, tlb_vpn2, tlb_odd, tlb_asid},
        {4'b0, va[31:13], va[12], asid_exp});
    for (int i = 0; i < 2; i++) begin
      flush = (fl == 1 && i == 0);
      @(negedge clk);
      chk({nm, "_hold"},
          {3'b0, tlb_req, tlb_vpn2, tlb_odd, tlb_asid},
          {3'b0, 1'b1, va[31:13], va[12], asid_exp});
    end
    tlb_ack = 1'b1;
    tlb_hit = h;
    tlb_g   = g;
    tlb_d   = d;
    tlb_v   = v;
    tlb_pfn = pfn;
    tlb_c   = c;
    flush   = (fl == 2);
    @(posedge clk);
    #1;
    ackc = cyc;
    tlb_ack = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    chk({nm, "_drop"}, {31'b0, tlb_req}, 32'd0);
    wait_resp(n0, nm);
    chk({nm, "_lat"}, resp_cyc - ackc, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n0;
    bit seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_ctl",
        {28'b0, tlb_req, resp_valid, resp_exc, resp_refill},
        32'd0);
    chk("rst_data", {7'b0, resp_tag, resp_exccode}, 32'd0);
    rst = 1'b1;

    xlate("k0_cached", 32'h8000_1234, 1'b0,
          '{20'h00001, 1'b0, 1'b0, 5'd0, 1'b0});
    cp0_k0 = 3'd2;
    xlate("k0_uncached", 32'h8000_1234, 1'b0,
          '{20'h00001, 1'b1, 1'b0, 5'd0, 1'b0});
    cp0_k0 = 3'd3;
    xlate("kseg1", 32'hA000_2000, 1'b0,
          '{20'h00002, 1'b1, 1'b0, 5'd0, 1'b0});

    miss("fill_a", 32'h0040_3000, 1'b0, 8'd5,
         1'b1, 1'b0, 1'b1, 1'b1, 20'h1F003, 3'd3, 0,
         '{20'h1F003, 1'b0, 1'b0, 5'd0, 1'b0}, 2);
    xlate("hit_a", 32'h0040_3000, 1'b0,
          '{20'h1F003, 1'b0, 1'b0, 5'd0, 1'b0});
    miss("mod_b", 32'h0040_4000, 1'b1, 8'd5,
         1'b1, 1'b0, 1'b0, 1'b1, 20'h12345, 3'd2, 0,
         '{20'h12345, 1'b1, 1'b1, 5'd1, 1'b0}, 2);
    miss("tlbs_refill", 32'h0040_5000, 1'b1, 8'd5,
         1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 3'd0, 0,
         '{20'h0, 1'b0, 1'b1, 5'd3, 1'b1}, 0);
    miss("tlbs_nofill", 32'h0040_5000, 1'b1, 8'd5,
         1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 3'd0, 0,
         '{20'h0, 1'b0, 1'b1, 5'd3, 1'b1}, 0);
    miss("tlbl_inv", 32'h0040_6000, 1'b0, 8'd5,
         1'b1, 1'b0, 1'b1, 1'b0, 20'h00666, 3'd3, 0,
         '{20'h0, 1'b0, 1'b1, 5'd2, 1'b0}, 0);
    miss("tlbl_nofill", 32'h0040_6000, 1'b0, 8'd5,
         1'b1, 1'b0, 1'b1, 1'b0, 20'h00666, 3'd3, 0,
         '{20'h0, 1'b0, 1'b1, 5'd2, 1'b0}, 0);

    miss("fill_c", 32'h0040_7000, 1'b0, 8'd5,
         1'b1, 1'b0, 1'b1, 1'b1, 20'h00777, 3'd3, 0,
         '{20'h00777, 1'b0, 1'b0, 5'd0, 1'b0}, 2);
    miss("fill_g", 32'h0040_8000, 1'b0, 8'd5,
         1'b1, 1'b1, 1'b1, 1'b1, 20'h00888, 3'd0, 0,
         '{20'h00888, 1'b1, 1'b0, 5'd0, 1'b0}, 2);
    miss("fill_e", 32'h0040_9000, 1'b0, 8'd5,
         1'b1, 1'b0, 1'b1, 1'b1, 20'h00999, 3'd3, 0,
         '{20'h00999, 1'b0, 1'b0, 5'd0, 1'b0}, 2);
    miss("evicted", 32'h0040_3000, 1'b0, 8'd5,
         1'b1, 1'b0, 1'b1, 1'b1, 20'h1F003, 3'd3, 0,
         '{20'h1F003, 1'b0, 1'b0, 5'd0, 1'b0}, 2);

    xlate("asid_inflight", 32'h0040_9000, 1'b0,
          '{20'h00999, 1'b0, 1'b0, 5'd0, 1'b0},
          1'b1, 8'd6);
    miss("asid_miss", 32'h0040_7000, 1'b0, 8'd6,
         1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 3'd0, 0,
         '{20'h0, 1'b0, 1'b1, 5'd2, 1'b1}, 0);
    xlate("global_hit", 32'h0040_8000, 1'b0,
          '{20'h00888, 1'b1, 1'b0, 5'd0, 1'b0});

    miss("flush_wait", 32'h0040_A000, 1'b0, 8'd6,
         1'b1, 1'b0, 1'b1, 1'b1, 20'h0ABCD, 3'd3, 1,
         '{20'h0ABCD, 1'b0, 1'b0, 5'd0, 1'b0}, 0);
    miss("after_flush", 32'h0040_A000, 1'b0, 8'd6,
         1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 3'd0, 0,
         '{20'h0, 1'b0, 1'b1, 5'd2, 1'b1}, 0);
    miss("flush_global", 32'h0040_8000, 1'b0, 8'd6,
         1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 3'd0, 0,
         '{20'h0, 1'b0, 1'b1, 5'd2, 1'b1}, 0);
    miss("flush_ack_mod", 32'h0040_B000, 1'b1, 8'd6,
         1'b1, 1'b0, 1'b0, 1'b1, 20'h00B0B, 3'd0, 2,
         '{20'h00B0B, 1'b1, 1'b1, 5'd1, 1'b0}, 0);
    miss("flush_ack_nofill", 32'h0040_B000, 1'b1, 8'd6,
         1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 3'd0, 0,
         '{20'h0, 1'b0, 1'b1, 5'd3, 1'b1}, 0);

    // reset while the main-TLB lookup is outstanding
    n0 = resp_cnt;
    issue(32'h0040_C000, 1'b0, acc);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = tlb_req;
    end
    chk("rst_wait_req", {31'b0, seen}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_wait_tlbreq", {31'b0, tlb_req}, 32'd0);
    rst = 1'b1;
    tlb_ack = 1'b1;
    tlb_hit = 1'b1;
    tlb_v   = 1'b1;
    tlb_d   = 1'b1;
    tlb_pfn = 20'h0CCCC;
    @(posedge clk);
    #1;
    tlb_ack = 1'b0;
    repeat (5) @(posedge clk);
    chk("late_ack", resp_cnt - n0, 32'd0);

    xlate("post_rst", 32'hA000_5000, 1'b0,
          '{20'h00005, 1'b1, 1'b0, 5'd0, 1'b0});

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
